// File: rtl/tcdm_init_master.sv
// Memory fill/check engine for a TCDM port: writes pattern^index to num_words
// consecutive words, then (with readback) reads them back and counts mismatches.
// Latency: one request per cycle while granted; done_o pulses one cycle after
// the last write grant (no readback) or two cycles after the last read grant.
// Backpressure: request outputs hold steady until tcdm_gnt_i; index only moves
// on a grant.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   start_i                    start a run (honoured only when idle)
//   base_addr_i, num_words_i,  run configuration, sampled on the start cycle
//   pattern_i
//   busy_o, done_o             run in progress / one-cycle end-of-run pulse
//   err_cnt_o                  saturating readback mismatch count
//   first_err_addr_o           address of the first mismatch of the run
//   tcdm_*_o / tcdm_*_i        TCDM request (req/add/wen/data/be/id, gnt)
//                              and response (r_data, r_id - id is ignored)
//
// Build option: define TCDM_INIT_READBACK_EN to compile in the readback check.
// Without it the run ends after the last write and the error outputs are 0.

module tcdm_init_master #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [AddrWidth-1:0]   base_addr_i,
  input  logic [CntWidth-1:0]    num_words_i,
  input  logic [DataWidth-1:0]   pattern_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CntWidth-1:0]    err_cnt_o,
  output logic [AddrWidth-1:0]   first_err_addr_o,
  output logic                   tcdm_req_o,
  output logic [AddrWidth-1:0]   tcdm_add_o,
  output logic                   tcdm_wen_o,
  output logic [DataWidth-1:0]   tcdm_data_o,
  output logic [DataWidth/8-1:0] tcdm_be_o,
  output logic [IdWidth-1:0]     tcdm_id_o,
  input  logic                   tcdm_gnt_i,
  input  logic [DataWidth-1:0]   tcdm_r_data_i,
  input  logic [IdWidth-1:0]     tcdm_r_id_i
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CntWidth-1:0]  idx_q, idx_d;
  logic [AddrWidth-1:0] base_q;
  logic [CntWidth-1:0]  num_q;
  logic [DataWidth-1:0] pat_q;

  logic                 start_run;
  logic                 last_word;
  logic [AddrWidth-1:0] cur_addr;
  logic [DataWidth-1:0] cur_data;

  assign start_run = (state_q == IDLE) && start_i;
  assign last_word = (idx_q == (num_q - CntWidth'(1)));
  // Word addressing: byte address advances by 4 per index, wrapping naturally.
  assign cur_addr  = base_q + (AddrWidth'(idx_q) << 2);
  assign cur_data  = pat_q ^ DataWidth'(idx_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tcdm_req_o  = 1'b0;
    tcdm_wen_o  = 1'b1;
    tcdm_add_o  = '0;
    tcdm_data_o = '0;
    tcdm_be_o   = '0;
    tcdm_id_o   = '0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          idx_d   = '0;
          state_d = (num_words_i == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        tcdm_req_o  = 1'b1;
        tcdm_wen_o  = 1'b0;
        tcdm_add_o  = cur_addr;
        tcdm_data_o = cur_data;
        tcdm_be_o   = '1;
        busy_o      = 1'b1;
        if (tcdm_gnt_i) begin
          idx_d = idx_q + CntWidth'(1);
          if (last_word) begin
            idx_d = '0;
`ifdef TCDM_INIT_READBACK_EN
            state_d = READ;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef TCDM_INIT_READBACK_EN
      READ: begin
        tcdm_req_o = 1'b1;
        tcdm_add_o = cur_addr;
        tcdm_be_o  = '1;
        busy_o     = 1'b1;
        if (tcdm_gnt_i) begin
          idx_d = idx_q + CntWidth'(1);
          if (last_word) begin
            idx_d   = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Last read response is compared this cycle by the pending register.
        busy_o  = 1'b1;
        state_d = DONE;
      end
`endif
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      num_q   <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (start_run) begin
        base_q <= base_addr_i;
        num_q  <= num_words_i;
        pat_q  <= pattern_i;
      end
    end
  end

`ifdef TCDM_INIT_READBACK_EN
  // One-entry pending slot: a read granted this cycle is checked next cycle,
  // and may be overwritten by the following grant in that same cycle.
  logic                 pend_vld_q;
  logic [DataWidth-1:0] pend_exp_q;
  logic [AddrWidth-1:0] pend_addr_q;
  logic [CntWidth-1:0]  err_cnt_q;
  logic [AddrWidth-1:0] first_err_q;
  logic                 rd_gnt;
  logic                 mismatch;
  logic                 unused_ok;

  assign rd_gnt    = (state_q == READ) && tcdm_gnt_i;
  assign mismatch  = pend_vld_q && (tcdm_r_data_i != pend_exp_q);
  assign unused_ok = ^tcdm_r_id_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_vld_q  <= 1'b0;
      pend_exp_q  <= '0;
      pend_addr_q <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      pend_vld_q <= rd_gnt;
      if (rd_gnt) begin
        pend_exp_q  <= cur_data;
        pend_addr_q <= cur_addr;
      end
      if (start_run) begin
        err_cnt_q   <= '0;
        first_err_q <= '0;
      end else if (mismatch) begin
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CntWidth'(1);
        // The counter saturates and never returns to zero within a run,
        // so zero identifies the first mismatch.
        if (err_cnt_q == '0) first_err_q <= pend_addr_q;
      end
    end
  end

  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;
`else
  logic unused_ok;
  assign unused_ok        = ^{tcdm_r_data_i, tcdm_r_id_i};
  assign err_cnt_o        = '0;
  assign first_err_addr_o = '0;
`endif

endmodule

// File: doc/tcdm_init_master.md
TCDM_INIT_MASTER -- requirements
Module: tcdm_init_master

Interface
REQ-001 SHALL have parameter AddrWidth, default 32: width of the TCDM address.
REQ-002 SHALL have parameter DataWidth, default 32: width of the TCDM data word.
REQ-003 SHALL have parameter IdWidth, default 1: width of the request and response ID.
REQ-004 SHALL have parameter CntWidth, default 16: width of the word counter and the error counter.
REQ-005 SHALL have port clk_i, input, 1: the single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port start_i, input, 1: starts a run when idle.
REQ-008 SHALL have ports base_addr_i, input, AddrWidth; num_words_i, input, CntWidth; pattern_i, input, DataWidth; all three sampled when a run starts.
REQ-009 SHALL have ports busy_o, output, 1; done_o, output, 1, one-cycle pulse at the end of a run.
REQ-010 SHALL have ports err_cnt_o, output, CntWidth; first_err_addr_o, output, AddrWidth.
REQ-011 SHALL have ports tcdm_req_o, output, 1; tcdm_add_o, output, AddrWidth; tcdm_wen_o, output, 1, where 0 means write; tcdm_data_o, output, DataWidth; tcdm_be_o, output, DataWidth/8; tcdm_id_o, output, IdWidth.
REQ-012 SHALL have ports tcdm_gnt_i, input, 1; tcdm_r_data_i, input, DataWidth; tcdm_r_id_i, input, IdWidth.

Function
REQ-013 SHALL implement a state machine with states IDLE, WRITE, READ, DRAIN and DONE.
REQ-014 IDLE, on start_i=1: SHALL latch the inputs of REQ-008, clear err_cnt_o and first_err_addr_o, and set index=0.
  - Next state is WRITE, or DONE if num_words_i=0.
  - start_i SHALL be ignored in all states other than IDLE.
REQ-015 In WRITE and READ, tcdm_req_o SHALL be 1.
  - tcdm_add_o = base + 4*index, modulo 2^AddrWidth; wrap-around is allowed.
  - tcdm_be_o = all ones; tcdm_id_o = 0.
REQ-016 The request outputs SHALL stay stable until tcdm_gnt_i=1. A request is granted only in a cycle where tcdm_req_o=1 and tcdm_gnt_i=1; index increments by 1 only on a grant.
REQ-017 In WRITE, tcdm_wen_o=0 and tcdm_data_o = pattern XOR index, with index zero-extended to DataWidth.
REQ-018 On the grant of word num_words-1 in WRITE: index SHALL reset to 0 and the state SHALL go to READ, with no idle cycle between the last write and the first read.
REQ-019 In READ, tcdm_wen_o=1. Each read grant SHALL set a one-entry pending register holding the expected data and the address.
REQ-020 One cycle after each read grant, the block SHALL compare tcdm_r_data_i against the expected data.
  - On mismatch: err_cnt_o increments, saturating at all ones.
  - On the first mismatch of the run: first_err_addr_o captures the address.
REQ-021 A read grant and a compare in the same cycle SHALL both take effect: the pending register reloads while the previous response is checked.
REQ-022 On the grant of the last read, the state SHALL go to DRAIN. DRAIN SHALL perform the final compare and then go to DONE; tcdm_req_o=0 in DRAIN.
REQ-023 DONE SHALL last one cycle with done_o=1, then go to IDLE.
REQ-024 busy_o=1 in WRITE, READ and DRAIN; busy_o=0 in IDLE and DONE.
REQ-025 tcdm_r_id_i SHALL be ignored for checking.
REQ-026 err_cnt_o and first_err_addr_o SHALL hold their values until the next start.

Reset
REQ-027 With rst_i=1 at a clock edge, the block SHALL enter IDLE; in-flight requests and responses are discarded.
REQ-028 After that edge, all outputs SHALL be 0: tcdm_req_o, busy_o, done_o, err_cnt_o, first_err_addr_o, tcdm_add_o, tcdm_data_o, tcdm_be_o and tcdm_id_o. The one exception is tcdm_wen_o=1.
REQ-029 Reset during WRITE, READ or DRAIN SHALL NOT produce a done_o pulse.

Configuration
REQ-030 Macro TCDM_INIT_READBACK_EN SHALL select whether the readback check is compiled in.
  - Defined: full behaviour of REQ-013 to REQ-026.
  - Undefined: READ and DRAIN are removed. The last write grant goes directly to DONE; err_cnt_o and first_err_addr_o are tied to 0.

Verification
REQ-031 Zero-wait fill and check: base=0x100, num=4, pattern=0xA5A5_0000, gnt always 1, memory model with latency 1.
  - Writes: 0x100..0x10C with data A5A5_0000..A5A5_0003.
  - Then 4 reads; done_o in the cycle after DRAIN; err_cnt_o=0.
REQ-032 Grant stall: gnt=0 for 3 cycles on the 2nd write.
  - tcdm_add_o=0x104 and tcdm_data_o stay stable for those cycles.
  - Total write grants = 4.
REQ-033 Fault injection: memory model corrupts the word at 0x108.
  - err_cnt_o=1 and first_err_addr_o=0x108.
  - A second corruption at 0x10C gives err_cnt_o=2 with first_err_addr_o unchanged.
REQ-034 Zero length: num=0.
  - No tcdm_req_o; done_o one cycle after the start cycle.
  - A start_i held during the run causes no restart.
REQ-035 Reset mid-run: rst_i=1 during READ.
  - The next cycle shows tcdm_req_o=0, busy_o=0, err_cnt_o=0, and no done_o pulse.
  - A new run afterwards passes.
REQ-036 Wrap-around: base=0xFFFF_FFF8, num=4.
  - Addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
  - Repeat with TCDM_INIT_READBACK_EN undefined: no reads, and done_o after the 4th write grant.
